// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants and state encoding for the stream mux
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with its own rotating priority pointer
// The pointer moves to one past the granted channel only when advance_i is pulsed.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int IDX_W    = $clog2(CHANNELS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] req_i,
  input  logic                advance_i,
  output logic [CHANNELS-1:0] grant_o,
  output logic [IDX_W-1:0]    grant_idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % CHANNELS);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o  = cand;
      end
    end
  end

  // Explicit wrap keeps non-power-of-two channel counts in range.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (grant_idx_o == IDX_W'(CHANNELS - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/stream_mux_n_to_1.sv
// rtl/stream_mux_n_to_1.sv - registered N-to-1 valid/ready stream mux
// Fixed-select or round-robin grant feeding a single-beat output register.
module stream_mux_n_to_1
  import stream_mux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int SEL_WIDTH = $clog2(CHANNELS)
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  input  logic [CHANNELS*WIDTH-1:0] i_Data,
  input  logic [CHANNELS-1:0]       i_Valid,
  output logic [CHANNELS-1:0]       o_Ready,
  input  logic                      i_Mode,
  input  logic [SEL_WIDTH-1:0]      i_Sel,
  output logic [WIDTH-1:0]          o_Data,
  output logic                      o_Valid,
  input  logic                      i_Ready,
  output logic [SEL_WIDTH-1:0]      o_Sel
);

  out_state_e           state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;

  logic [CHANNELS-1:0]  fixed_grant, rr_grant, grant;
  logic [SEL_WIDTH-1:0] rr_idx, grant_idx;
  logic [WIDTH-1:0]     sel_data;
  logic                 load_en, accept, advance;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .IDX_W    (SEL_WIDTH)
  ) u_rr_arbiter (
    .clk_i       (i_Clk),
    .rst_i       (i_Rst),
    .req_i       (i_Valid),
    .advance_i   (advance),
    .grant_o     (rr_grant),
    .grant_idx_o (rr_idx)
  );

  // An out-of-range select simply matches no channel.
  always_comb begin
    fixed_grant = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      fixed_grant[k] = i_Valid[k] && (int'(i_Sel) == k);
    end
  end

  assign grant     = (i_Mode == MODE_RR) ? rr_grant : fixed_grant;
  assign grant_idx = (i_Mode == MODE_RR) ? rr_idx : i_Sel;
  assign load_en   = (state_q == ST_EMPTY) | i_Ready;
  assign o_Ready   = grant & {CHANNELS{load_en & ~i_Rst}};
  assign accept    = |o_Ready;
  assign advance   = accept & (i_Mode == MODE_RR);

  // AND-OR select so unknowns on ungranted channels are masked off.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_data = sel_data | (i_Data[k*WIDTH +: WIDTH] & {WIDTH{grant[k]}});
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (accept) begin
      state_d = ST_FULL;
      data_d  = sel_data;
      sel_d   = grant_idx;
    end else if (state_q == ST_FULL && i_Ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign o_Valid = (state_q == ST_FULL);
  assign o_Data  = data_q;
  assign o_Sel   = sel_q;

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// tb/tb_stream_mux_n_to_1.sv - directed bench with a behavioural model of the stream mux
module tb_stream_mux_n_to_1;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int SW = 2;

  logic            i_Clk = 1'b0;
  logic            i_Rst;
  logic [CH*W-1:0] i_Data;
  logic [CH-1:0]   i_Valid;
  logic [CH-1:0]   o_Ready;
  logic            i_Mode;
  logic [SW-1:0]   i_Sel;
  logic [W-1:0]    o_Data;
  logic            o_Valid;
  logic            i_Ready;
  logic [SW-1:0]   o_Sel;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: one-entry output slot plus the rotating priority pointer.
  bit         m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  int         m_sel   = 0;
  int         m_ptr   = 0;

  stream_mux_n_to_1 #(.WIDTH(W), .CHANNELS(CH), .SEL_WIDTH(SW)) dut (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Data  (i_Data),
    .i_Valid (i_Valid),
    .o_Ready (o_Ready),
    .i_Mode  (i_Mode),
    .i_Sel   (i_Sel),
    .o_Data  (o_Data),
    .o_Valid (o_Valid),
    .i_Ready (i_Ready),
    .o_Sel   (o_Sel)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Channel that would be served this cycle, -1 if none.
  function automatic int model_pick();
    if (i_Mode == 1'b0) begin
      if (int'(i_Sel) < CH && i_Valid[i_Sel]) return int'(i_Sel);
      return -1;
    end
    for (int i = 0; i < CH; i++) begin
      if (i_Valid[(m_ptr + i) % CH]) return (m_ptr + i) % CH;
    end
    return -1;
  endfunction

  function automatic int model_take();
    if (i_Rst || (m_valid && !i_Ready)) return -1;
    return model_pick();
  endfunction

  always @(negedge i_Clk) begin
    int g;
    g = model_take();
    chk("o_Ready", 32'(o_Ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("o_Valid", 32'(o_Valid), 32'(m_valid));
    if (m_valid) begin
      chk("o_Data", 32'(o_Data), 32'(m_data));
      chk("o_Sel", 32'(o_Sel), 32'(m_sel));
    end
  end

  always @(posedge i_Clk) begin
    int g;
    g = model_take();
    if (i_Rst) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_sel   <= 0;
      m_ptr   <= 0;
    end else if (g >= 0) begin
      m_valid <= 1'b1;
      m_data  <= i_Data[g*W +: W];
      m_sel   <= g;
      if (i_Mode) m_ptr <= (g + 1) % CH;
    end else if (m_valid && i_Ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic edge1();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ready;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int exp_rr[6];
    int exp_sp[4];
    exp_rr = '{0, 1, 2, 3, 0, 1};
    exp_sp = '{1, 3, 1, 3};
    vecs[0]  = '{1'b1, 2'd0, 4'b1111, 1'b0};
    vecs[1]  = '{1'b1, 2'd0, 4'b1111, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 4'b0110, 1'b1};
    vecs[3]  = '{1'b0, 2'd3, 4'b0110, 1'b1};
    vecs[4]  = '{1'b0, 2'd1, 4'b0110, 1'b1};
    vecs[5]  = '{1'b0, 2'd1, 4'b0000, 1'b1};
    vecs[6]  = '{1'b0, 2'd1, 4'b0000, 1'b1};
    vecs[7]  = '{1'b1, 2'd0, 4'b1001, 1'b1};
    vecs[8]  = '{1'b1, 2'd0, 4'b1001, 1'b0};
    vecs[9]  = '{1'b1, 2'd0, 4'b1101, 1'b1};
    vecs[10] = '{1'b1, 2'd0, 4'b1101, 1'b1};
    vecs[11] = '{1'b1, 2'd2, 4'b0000, 1'b1};

    i_Rst   = 1'b1;
    i_Data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    i_Valid = 4'b1111;
    i_Mode  = 1'b1;
    i_Sel   = 2'd0;
    i_Ready = 1'b1;
    edge1();
    edge1();
    settle();
    chk("rst_valid", 32'(o_Valid), 32'd0);
    chk("rst_data", 32'(o_Data), 32'd0);
    chk("rst_sel", 32'(o_Sel), 32'd0);
    chk("rst_ready", 32'(o_Ready), 32'b0000);
    i_Rst = 1'b0;
    settle();
    chk("rel_rr_ready", 32'(o_Ready), 32'b0001);

    i_Mode = 1'b0;
    i_Sel  = 2'd2;
    settle();
    chk("fix2_ready", 32'(o_Ready), 32'b0100);
    edge1();
    settle();
    chk("fix2_data", 32'(o_Data), 32'hA2);
    chk("fix2_sel", 32'(o_Sel), 32'd2);
    i_Sel = 2'd3;
    settle();
    chk("fix3_ready", 32'(o_Ready), 32'b1000);
    edge1();

    i_Mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edge1();
      settle();
      chk("rr_sel", 32'(o_Sel), 32'(exp_rr[i]));
      chk("rr_valid", 32'(o_Valid), 32'd1);
    end

    i_Rst = 1'b1;
    edge1();
    i_Rst   = 1'b0;
    i_Valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      edge1();
      settle();
      chk("sparse_sel", 32'(o_Sel), 32'(exp_sp[i]));
    end
    i_Valid = 4'b0010;
    edge1();
    edge1();
    settle();
    chk("only1_sel", 32'(o_Sel), 32'd1);
    i_Valid = 4'b0011;
    edge1();
    settle();
    chk("wrap_sel", 32'(o_Sel), 32'd0);
    edge1();
    settle();
    chk("pre_bp_data", 32'(o_Data), 32'hA1);

    i_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_ready", 32'(o_Ready), 32'b0000);
      edge1();
      settle();
      chk("bp_data", 32'(o_Data), 32'hA1);
      chk("bp_valid", 32'(o_Valid), 32'd1);
    end
    i_Ready = 1'b1;
    settle();
    chk("bp_release_ready", 32'(o_Ready), 32'b0001);
    edge1();
    settle();
    chk("bp_next_data", 32'(o_Data), 32'hA0);

    i_Ready = 1'b0;
    i_Rst   = 1'b1;
    settle();
    chk("midrst_ready", 32'(o_Ready), 32'b0000);
    edge1();
    i_Rst = 1'b0;
    settle();
    chk("midrst_valid", 32'(o_Valid), 32'd0);
    chk("midrst_ptr_ready", 32'(o_Ready), 32'b0001);

    i_Mode  = 1'b0;
    i_Sel   = 2'd1;
    i_Valid = 4'b0010;
    i_Ready = 1'b1;
    i_Data[2*W +: W] = 8'hxx;
    edge1();
    settle();
    chk("xmask_data", 32'(o_Data), 32'hA1);
    i_Data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    foreach (vecs[i]) begin
      i_Mode  = vecs[i].mode;
      i_Sel   = vecs[i].sel;
      i_Valid = vecs[i].valid;
      i_Ready = vecs[i].ready;
      i_Data  = {8'h30, 8'h20, 8'h10, 8'h00} + {4{8'(i)}};
      edge1();
    end
    edge1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
